// File: rtl/gp_rename_reg_file.sv
// Tag-renamed general-purpose register file: each register is either valid or waiting on a
// reservation-station tag, and result broadcasts are captured by tag match rather than by address.
module gp_rename_reg_file #(
    parameter int READ_PORTS   = 2,
    parameter int WRITE_PORTS  = 2,
    parameter int UPDATE_PORTS = 1,
    parameter int REG_COUNT    = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int RS_ID_WIDTH  = 5,
    localparam int ADDR_WIDTH  = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [0:ADDR_WIDTH-1]    read_addr        [0:READ_PORTS-1],
    output logic                     read_value_valid [0:READ_PORTS-1],
    output logic [0:DATA_WIDTH-1]    read_value       [0:READ_PORTS-1],
    output logic [0:RS_ID_WIDTH-1]   read_rs_id       [0:READ_PORTS-1],
    input  logic                     write_enable     [0:WRITE_PORTS-1],
    input  logic [0:RS_ID_WIDTH-1]   write_rs_id      [0:WRITE_PORTS-1],
    input  logic [0:DATA_WIDTH-1]    write_value      [0:WRITE_PORTS-1],
    input  logic [0:ADDR_WIDTH-1]    update_addr      [0:UPDATE_PORTS-1],
    input  logic                     update_enable    [0:UPDATE_PORTS-1],
    input  logic [0:RS_ID_WIDTH-1]   update_rs_id     [0:UPDATE_PORTS-1],
    input  logic                     flush,
    output logic [0:ADDR_WIDTH]      pending_count
);

    logic                   valid_r   [0:REG_COUNT-1];
    logic [0:DATA_WIDTH-1]  value_r   [0:REG_COUNT-1];
    logic [0:RS_ID_WIDTH-1] rs_id_r   [0:REG_COUNT-1];
    logic [0:ADDR_WIDTH]    pend_cnt_r;

    logic                   wr_hit_s  [0:REG_COUNT-1];
    logic [0:DATA_WIDTH-1]  wr_val_s  [0:REG_COUNT-1];
    logic                   upd_hit_s [0:REG_COUNT-1];
    logic [0:RS_ID_WIDTH-1] upd_id_s  [0:REG_COUNT-1];

    logic                   valid_s   [0:REG_COUNT-1];
    logic [0:DATA_WIDTH-1]  value_s   [0:REG_COUNT-1];
    logic [0:RS_ID_WIDTH-1] rs_id_s   [0:REG_COUNT-1];
    logic [0:ADDR_WIDTH]    pend_s;

    // Tag match of every waiting register against the broadcasts; scanning down makes port 0 win.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            wr_hit_s[i] = 1'b0;
            wr_val_s[i] = '0;
            for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
                wr_val_s[i] = (write_enable[w] && !valid_r[i] && (write_rs_id[w] == rs_id_r[i]))
                              ? write_value[w] : wr_val_s[i];
                wr_hit_s[i] = wr_hit_s[i] |
                              (write_enable[w] && !valid_r[i] && (write_rs_id[w] == rs_id_r[i]));
            end
        end
    end

    // Rename decode per register; scanning up lets the youngest (highest) update port win.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            upd_hit_s[i] = 1'b0;
            upd_id_s[i]  = '0;
            for (int u = 0; u < UPDATE_PORTS; u++) begin
                upd_id_s[i]  = (update_enable[u] && (update_addr[u] == ADDR_WIDTH'(i)))
                               ? update_rs_id[u] : upd_id_s[i];
                upd_hit_s[i] = upd_hit_s[i] |
                               (update_enable[u] && (update_addr[u] == ADDR_WIDTH'(i)));
            end
        end
    end

    // Next-state merge: flush beats renames, a rename beats a same-cycle capture.
    always_comb begin
        pend_s = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            valid_s[i] = valid_r[i];
            value_s[i] = value_r[i];
            rs_id_s[i] = rs_id_r[i];
            if (flush) begin
                valid_s[i] = 1'b1;
                value_s[i] = wr_hit_s[i] ? wr_val_s[i] : value_r[i];
            end else if (upd_hit_s[i]) begin
                valid_s[i] = 1'b0;
                rs_id_s[i] = upd_id_s[i];
            end else begin
                valid_s[i] = valid_r[i] | wr_hit_s[i];
                value_s[i] = wr_hit_s[i] ? wr_val_s[i] : value_r[i];
            end
            pend_s = pend_s + (ADDR_WIDTH + 1)'(!valid_s[i]);
        end
    end

    // Register state and the pending counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                valid_r[i] <= 1'b1;
                value_r[i] <= '0;
                rs_id_r[i] <= '0;
            end
            pend_cnt_r <= '0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                valid_r[i] <= valid_s[i];
                value_r[i] <= value_s[i];
                rs_id_r[i] <= rs_id_s[i];
            end
            pend_cnt_r <= pend_s;
        end
    end

    assign pending_count = pend_cnt_r;

    // Zero-latency reads of the current state with same-cycle broadcast forwarding.
    always_comb begin
        for (int r = 0; r < READ_PORTS; r++) begin
            read_value_valid[r] = 1'b1;
            read_value[r]       = '0;
            read_rs_id[r]       = '0;
            if ({1'b0, read_addr[r]} < (ADDR_WIDTH + 1)'(REG_COUNT)) begin
                read_value_valid[r] = valid_r[read_addr[r]] | wr_hit_s[read_addr[r]];
                read_value[r]       = wr_hit_s[read_addr[r]] ? wr_val_s[read_addr[r]]
                                                             : value_r[read_addr[r]];
                read_rs_id[r]       = rs_id_r[read_addr[r]];
            end else begin
                read_value_valid[r] = 1'b1;
                read_value[r]       = '0;
                read_rs_id[r]       = '0;
            end
        end
    end

endmodule

// File: doc/gp_rename_reg_file.md
GP_RENAME_REG_FILE -- requirements
Module: gp_rename_reg_file

Interface
REQ-001 The module SHALL have the following parameters:
- READ_PORTS, default 2, number of read ports.
- WRITE_PORTS, default 2, number of result-broadcast ports.
- UPDATE_PORTS, default 1, number of rename/invalidate ports.
- REG_COUNT, default 32, number of registers.
- DATA_WIDTH, default 32, register value width.
- RS_ID_WIDTH, default 5, reservation station ID width.
REQ-002 The module SHALL derive localparam ADDR_WIDTH = $clog2(REG_COUNT), with a minimum of 1.
REQ-003 The module SHALL have the following ports (all vectors MSB-first [0:N-1], port arrays [0:PORTS-1]):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- read_addr  in  ADDR_WIDTH x READ_PORTS  register to read.
- read_value_valid  out  1 x READ_PORTS  register content valid.
- read_value  out  DATA_WIDTH x READ_PORTS  register content.
- read_rs_id  out  RS_ID_WIDTH x READ_PORTS  producing reservation station ID.
- write_enable  in  1 x WRITE_PORTS  result broadcast valid.
- write_rs_id  in  RS_ID_WIDTH x WRITE_PORTS  tag of the producing reservation station.
- write_value  in  DATA_WIDTH x WRITE_PORTS  result value.
- update_addr  in  ADDR_WIDTH x UPDATE_PORTS  register being renamed.
- update_enable  in  1 x UPDATE_PORTS  rename request.
- update_rs_id  in  RS_ID_WIDTH x UPDATE_PORTS  new producer tag.
- flush  in  1  discard all pending renames.
- pending_count  out  ADDR_WIDTH+1  number of registers with valid=0.

Function
REQ-004 Each register SHALL hold three fields: valid (1 bit), value (DATA_WIDTH bits) and rs_id (RS_ID_WIDTH bits).
REQ-005 Write capture: on a clock edge, a register SHALL capture write_value[w] and set valid=1 when all of the following hold: write_enable[w]=1, the register has valid=0, and its rs_id equals write_rs_id[w].
REQ-006 Writes are tag-matched, not addressed; one broadcast SHALL update every register waiting on that tag.
REQ-007 A register with valid=1 SHALL ignore all writes, so stale results never overwrite architectural state.
REQ-008 If several write ports match the same register in one cycle, the lowest port index SHALL win.
REQ-009 Update: on a clock edge with update_enable[u]=1, register update_addr[u] SHALL be set to valid=0 and rs_id=update_rs_id[u]; its value is unchanged.
REQ-010 If several update ports target the same address in one cycle, the highest port index SHALL win, since it is the youngest rename.
REQ-011 Update and a matching write on the same register in the same cycle: the update SHALL win (valid=0, new rs_id), and the write's value is discarded.
REQ-012 Read is combinational (zero latency) and SHALL return the state as of the start of the cycle, with same-cycle write forwarding applied.
REQ-013 Read forwarding: if the addressed register has valid=0 and a write port matches its rs_id this cycle, the read SHALL return valid=1 and the winning write_value (per REQ-008), with rs_id unchanged.
REQ-014 Same-cycle updates SHALL NOT be visible on read ports; they take effect from the next cycle.
REQ-015 Flush: on a clock edge with flush=1, the following SHALL happen:
- Every register is set to valid=1.
- All update_enable requests are ignored.
- Write captures per REQ-005 are still applied first, so matching registers take the broadcast value.
- Non-matching registers keep their old value.
REQ-016 pending_count SHALL be registered, and SHALL equal the count of valid=0 registers after the same clock edge's updates.
REQ-017 pending_count range SHALL be 0..REG_COUNT, with no wrap.
REQ-018 Out-of-range addresses (>= REG_COUNT, possible when REG_COUNT is not a power of 2) SHALL be handled as follows:
- Updates to them are ignored.
- Reads of them return valid=1, value=0, rs_id=0.

Reset
REQ-019 On a clock edge with rst=1, every register SHALL become valid=1, value=0, rs_id=0, and pending_count SHALL become 0.
REQ-020 rst SHALL take priority over flush, write and update inputs in the same cycle.
REQ-021 Reset asserted mid-operation SHALL discard all pending renames, and no in-flight write is captured.
REQ-022 After reset, every read SHALL return valid=1, value=0, rs_id=0.

Verification
REQ-023 Rename then broadcast:
- Stimulus: update r3 with tag 7; next cycle, write tag 7 with value 0xDEADBEEF.
- Response: during the write cycle, read r3 gives valid=1 and 0xDEADBEEF via forwarding; the following cycle it is registered valid=1; pending_count goes 1 -> 0.
REQ-024 Multi-register broadcast:
- Stimulus: rename r1 and r2 to tag 4 (over two cycles); write tag 4 with value 0x11.
- Response: both registers become valid with 0x11; pending_count goes 2 -> 0.
REQ-025 Stale result:
- Stimulus: rename r5 to tag 2; then rename r5 to tag 9; then write tag 2 with value 0x55.
- Response: r5 stays valid=0 with rs_id=9 and its old value; a later write of tag 9 with 0x66 gives r5 valid with 0x66.
REQ-026 Collision:
- Stimulus: in the same cycle, update r8 to tag 3 and write the tag currently held by r8 with value 0xAA.
- Response: r8 becomes valid=0 with rs_id=3, and 0xAA is not stored; with two update ports both targeting r8 (tags 1 and 2), rs_id becomes 2.
REQ-027 Flush:
- Stimulus: with r1 pending on tag 6 and r2 pending on tag 7, assert flush together with a write of tag 6 value 0x77 and an update of r4.
- Response: r1 becomes valid with 0x77; r2 becomes valid with its old value; r4 is unchanged; pending_count becomes 0.
REQ-028 Reset mid-operation:
- Stimulus: with 3 registers pending, assert rst together with a matching write.
- Response: all registers read valid=1, 0, rs_id=0, and pending_count becomes 0.
